rd_master_arbiter: RTL and testbench

Round-robin arbiter that shares the single Avalon read master among up to N_REQ clients: the look-at loader, the OBJ vertex fetcher, and the diffuse, normal and specular texture fetchers. It sits between those clients and the read master's start_read / length_read / RM_startaddress / RM_done port. It latches one client's address and length per transaction and holds start_read until RM_done. It returns a per-client completion pulse and fails a hung transfer with a programmable watchdog.

---
 rtl/rd_master_arbiter_if.sv | 29 ++
 rtl/rd_master_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rd_master_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_master_arbiter_if.sv
// Signal bundle between the read-master clients, the arbiter and the Avalon read master.
// The master modport is the arbiter's view; slave is the clients/read-master side.
interface rd_master_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*ADDR_W-1:0] req_len;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic                    err;
    logic                    start_read;
    logic [ADDR_W-1:0]       length_read;
    logic [ADDR_W-1:0]       RM_startaddress;
    logic                    RM_done;
    logic                    busy;
    logic [2:0]              owner_idx;

    modport master (
        input  req, req_addr, req_len, RM_done,
        output grant, done, err, start_read, length_read, RM_startaddress, busy, owner_idx
    );

    modport slave (
        output req, req_addr, req_len, RM_done,
        input  grant, done, err, start_read, length_read, RM_startaddress, busy, owner_idx
    );
endinterface

// File: rtl/rd_master_arbiter.sv
// Round-robin owner of the single Avalon read master: latches one client's address/length,
// holds start_read until RM_done, pulses done[owner], and fails hung transfers via a watchdog.
module rd_master_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                clk,
    input  logic                rst,
    rd_master_arbiter_if.master bus
);
    localparam int              IDX_W    = $clog2(N_REQ);
    localparam bit              WD_EN    = (TIMEOUT_CYC != 0);
    localparam logic [ADDR_W:0] WD_LIMIT = (ADDR_W + 1)'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   wdog_q, wdog_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [2:0]          owner_q, owner_d;

    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    logic [ADDR_W-1:0]   len_arr  [N_REQ];
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [N_REQ-1:0]    win_onehot;
    logic [ADDR_W-1:0]   wdog_inc;
    logic                wd_expire;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign len_arr[g]  = bus.req_len[g*ADDR_W +: ADDR_W];
    end

    // First requesting client searching upward from the one after the last owner, wrapping.
    always_comb begin : rr_search
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(last_q) + off) % N_REQ;
            if (!win_found && bus.req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    // The counter saturates so a hung transfer with the watchdog disabled never wraps.
    assign wdog_inc  = (wdog_q == '1) ? wdog_q : wdog_q + ADDR_W'(1);
    assign wd_expire = WD_EN && ({1'b0, wdog_inc} >= WD_LIMIT);

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = 1'b0;
        start_d = start_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wdog_d  = wdog_q;
        last_d  = last_q;
        owner_d = owner_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win_onehot;
                    last_d  = win_idx;
                    owner_d = 3'(win_idx);
                    addr_d  = addr_arr[win_idx];
                    len_d   = len_arr[win_idx];
                    busy_d  = 1'b1;
                    wdog_d  = '0;
                    if (len_arr[win_idx] == '0) begin
                        state_d = S_DONE;
                        done_d  = win_onehot;
                    end else begin
                        state_d = S_BUSY;
                        start_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                wdog_d = wdog_inc;
                // A completion coincident with expiry counts as a normal completion.
                if (bus.RM_done) begin
                    state_d = S_DONE;
                    start_d = 1'b0;
                    done_d  = grant_q;
                end else if (wd_expire) begin
                    state_d = S_DONE;
                    start_d = 1'b0;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                start_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        // NOTE: every flop here is reset, the latched address/length included, so an abandoned
        // transfer leaves nothing behind; there is no memory array that would need exempting.
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            wdog_q  <= '0;
            last_q  <= LAST_RST;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdog_q  <= wdog_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    assign bus.grant           = grant_q;
    assign bus.done            = done_q;
    assign bus.err             = err_q;
    assign bus.start_read      = start_q;
    assign bus.busy            = busy_q;
    assign bus.RM_startaddress = addr_q;
    assign bus.length_read     = len_q;
    assign bus.owner_idx       = owner_q;
endmodule

// File: tb/tb_rd_master_arbiter.sv
// Scoreboard bench for rd_master_arbiter: a transaction-level model predicts each completion,
// a monitor pops and compares on every done pulse, and a read-master model answers start_read.
module tb_rd_master_arbiter;
    localparam int N_REQ       = 4;
    localparam int ADDR_W      = 32;
    localparam int TIMEOUT_CYC = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rd_master_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) bus ();

    rd_master_arbiter #(
        .N_REQ      (N_REQ),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          owner;
        logic [31:0] addr;
        logic [31:0] len;
        int          sr_cycles;
        bit          err;
    } exp_t;

    exp_t             sb[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [N_REQ-1:0] pend;
    logic [31:0]      a[];
    logic [31:0]      l[];
    int               last_m;
    int               cur_w;
    int               lat_cur  = 0;
    int               stray_rm = 0;
    int               sr_cnt   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N_REQ-1:0] bit_of(int i);
        return N_REQ'(1) << i;
    endfunction

    // Round-robin rule: first pending client after the last owner, wrapping.
    function automatic int rr_winner(logic [N_REQ-1:0] p, int last);
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (last + k) % N_REQ;
            if (((p >> idx) & N_REQ'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    task automatic drive_bus();
        logic [N_REQ*ADDR_W-1:0] av, lv;
        av = '0;
        lv = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            av = (av << ADDR_W) | (N_REQ*ADDR_W)'(a[i]);
            lv = (lv << ADDR_W) | (N_REQ*ADDR_W)'(l[i]);
        end
        bus.req      = pend;
        bus.req_addr = av;
        bus.req_len  = lv;
    endtask

    task automatic raise(int i, logic [31:0] addr, logic [31:0] len);
        a[i] = addr;
        l[i] = len;
        pend = pend | bit_of(i);
    endtask

    // lat: cycle of start_read on which the read master answers; 0 means it never answers.
    task automatic arbitrate(int lat);
        exp_t e;
        int   w;
        drive_bus();
        w = rr_winner(pend, last_m);
        if (w < 0) return;
        e.owner = w;
        e.addr  = a[w];
        e.len   = l[w];
        if (l[w] == 0) begin
            e.sr_cycles = 0;
            e.err       = 1'b0;
        end else if (lat == 0) begin
            e.sr_cycles = TIMEOUT_CYC;
            e.err       = 1'b1;
        end else begin
            e.sr_cycles = lat;
            e.err       = 1'b0;
        end
        sb.push_back(e);
        lat_cur = lat;
        last_m  = w;
        cur_w   = w;
    endtask

    // Optionally scribble the owner's address and drop its request while the transfer runs.
    task automatic wait_done(bit corrupt);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.done != '0) begin
                seen = 1'b1;
            end else if (corrupt && c == 1) begin
                a[cur_w] = 32'h0000_DEAD;
                pend     = pend & ~bit_of(cur_w);
                drive_bus();
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        pend = pend & ~bit_of(cur_w);
        drive_bus();
    endtask

    task automatic check_reset(string tag);
        check({tag, "_grant"}, 64'(bus.grant), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
        check({tag, "_start_read"}, 64'(bus.start_read), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_owner_idx"}, 64'(bus.owner_idx), 64'd0);
        check({tag, "_addr"}, 64'(bus.RM_startaddress), 64'd0);
        check({tag, "_len"}, 64'(bus.length_read), 64'd0);
    endtask

    // Read-master model: answers after lat_cur cycles of start_read, plus stray pulses when idle.
    initial begin
        int rm_cnt;
        rm_cnt      = 0;
        bus.RM_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !bus.start_read) begin
                rm_cnt = 0;
                if (!rst && stray_rm > 0) begin
                    bus.RM_done = 1'b1;
                    stray_rm--;
                end else begin
                    bus.RM_done = 1'b0;
                end
            end else begin
                rm_cnt++;
                bus.RM_done = (lat_cur != 0 && rm_cnt == lat_cur);
            end
        end
    end

    // Monitor: compare every completion against the oldest predicted transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sr_cnt = 0;
            end else begin
                if (bus.start_read) sr_cnt++;
                if (bus.done != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 64'(bus.done), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("done_onehot", 64'(bus.done), 64'(bit_of(e.owner)));
                        check("grant", 64'(bus.grant), 64'(bit_of(e.owner)));
                        check("owner_idx", 64'(bus.owner_idx), 64'(e.owner));
                        check("err", 64'(bus.err), 64'(e.err));
                        check("rm_addr", 64'(bus.RM_startaddress), 64'(e.addr));
                        check("length_read", 64'(bus.length_read), 64'(e.len));
                        check("start_read_cycles", 64'(sr_cnt), 64'(e.sr_cycles));
                        check("start_read_low_at_done", 64'(bus.start_read), 64'd0);
                    end
                    sr_cnt = 0;
                end else if (bus.err) begin
                    check("err_without_done", 64'(bus.err), 64'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int prev;
        a    = new[N_REQ];
        l    = new[N_REQ];
        for (int i = 0; i < N_REQ; i++) begin
            a[i] = '0;
            l[i] = '0;
        end
        pend   = '0;
        last_m = N_REQ - 1;
        cur_w  = 0;
        rst    = 1'b1;
        drive_bus();
        repeat (2) @(negedge clk);
        check_reset("init");
        rst = 1'b0;
        @(negedge clk);

        // Single client 0, 10-cycle transfer.
        raise(0, 32'h1000, 32'd48);
        arbitrate(10);
        wait_done(1'b0);

        // All four requesting; each served client re-raises one transfer later.
        for (int i = 0; i < N_REQ; i++) raise(i, 32'h2000 + 32'(i) * 32'h100, 32'd64 + 32'(i));
        prev = -1;
        for (int t = 0; t < 5; t++) begin
            arbitrate(3);
            wait_done(1'b0);
            if (prev >= 0 && t < 4) raise(prev, 32'h2800 + 32'(t), 32'd16);
            prev = cur_w;
        end
        while (pend != '0) begin
            arbitrate(3);
            wait_done(1'b0);
        end

        // Zero-length request, then completion coincident with watchdog expiry.
        raise(2, 32'h3000, 32'd0);
        arbitrate(5);
        wait_done(1'b0);
        raise(1, 32'h3100, 32'd8);
        arbitrate(TIMEOUT_CYC);
        wait_done(1'b0);

        // Hung transfer, then late RM_done pulses while idle.
        raise(3, 32'h3200, 32'd200);
        arbitrate(0);
        wait_done(1'b0);
        stray_rm = 3;
        repeat (6) @(negedge clk);

        // Address scribbled and request dropped mid-transfer.
        raise(1, 32'h4000, 32'd128);
        arbitrate(8);
        wait_done(1'b1);

        // Reset during BUSY after client 0 owned the bus; 0101 must then go to client 0.
        raise(0, 32'h5000, 32'd16);
        arbitrate(15);
        repeat (4) @(negedge clk);
        rst  = 1'b1;
        pend = '0;
        drive_bus();
        sb.delete();
        @(negedge clk);
        check_reset("rst_mid");
        rst    = 1'b0;
        last_m = N_REQ - 1;
        @(negedge clk);
        raise(0, 32'h6000, 32'd32);
        raise(2, 32'h6200, 32'd40);
        arbitrate(4);
        wait_done(1'b0);
        arbitrate(2);
        wait_done(1'b0);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            if (pend == '0) begin
                repeat ($urandom_range(2, 4)) @(negedge clk);
                while (pend == '0) begin
                    for (int i = 0; i < N_REQ; i++)
                        if ($urandom_range(0, 1) == 1)
                            raise(i, $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 4096)));
                end
            end
            arbitrate(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT_CYC));
            wait_done($urandom_range(0, 7) == 0);
            for (int i = 0; i < N_REQ; i++)
                if (i != cur_w && ((pend >> i) & N_REQ'(1)) == '0 && $urandom_range(0, 2) == 0)
                    raise(i, $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 4096)));
        end
        while (pend != '0) begin
            arbitrate($urandom_range(1, 6));
            wait_done(1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
